// File: rtl/ibf_multi_bank_programmer.sv
// ibf_multi_bank_programmer
// Programs NUM_IBF invertible Bloom filter banks from a single element stream.
// Each accepted element updates K_HASH cells per enabled bank, one hash index
// per cycle, by read-modify-write on register-based banks, so repeated indexes
// within an element accumulate. A one-cycle-latency read port exposes the banks.
// Optional build macro IBF_COUNT_SAT_EN: saturating counts plus a sticky
// cnt_err output; without it counts wrap and cnt_err is absent.
module ibf_multi_bank_programmer #(
  parameter int KEY_W   = 32,
  parameter int SIG_W   = 8,
  parameter int CNT_W   = 4,
  parameter int IDX_W   = 4,
  parameter int NUM_IBF = 2,
  parameter int K_HASH  = 3,
  localparam int CELL_W = KEY_W + SIG_W + CNT_W,
  localparam int HASH_W = SIG_W + K_HASH * IDX_W,
  localparam int BANK_W = (NUM_IBF > 1) ? $clog2(NUM_IBF) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [NUM_IBF-1:0] in_bank_mask,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [HASH_W-1:0] in_hash,
  output logic              done,
  output logic              busy,
  input  logic              rd_en,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic              rd_valid,
  output logic [CELL_W-1:0] rd_data
`ifdef IBF_COUNT_SAT_EN
  ,
  output logic              cnt_err
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int J_W   = (K_HASH > 1) ? $clog2(K_HASH) : 1;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_UPDATE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     clr_addr_q, clr_addr_d;
  logic [J_W-1:0]       j_q, j_d;
  logic                 clr_pend_q, clr_pend_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [SIG_W-1:0]     sig_q, sig_d;
  logic [IDX_W-1:0]     idx_q [K_HASH];
  logic [IDX_W-1:0]     idx_d [K_HASH];
  logic                 op_q, op_d;
  logic [NUM_IBF-1:0]   mask_q, mask_d;
  logic [CELL_W-1:0]    mem_q [NUM_IBF][DEPTH];
  logic [CELL_W-1:0]    mem_d [NUM_IBF][DEPTH];
  logic                 rd_valid_q, rd_valid_d;
  logic [CELL_W-1:0]    rd_data_q, rd_data_d;

  logic [IDX_W-1:0]     cur_idx;
  logic [CELL_W-1:0]    old_cell;
  logic [CNT_W-1:0]     new_cnt;

`ifdef IBF_COUNT_SAT_EN
  logic                 cnt_err_q, cnt_err_d;
  logic                 sat_evt;
  logic                 sat_b;

  // Saturating count step; MSB of the result flags a saturation event.
  function automatic logic [CNT_W:0] cnt_upd(input logic [CNT_W-1:0] c, input logic op);
    if (!op) return (&c) ? {1'b1, c} : {1'b0, c + CNT_W'(1)};
    else     return (c == '0) ? {1'b1, c} : {1'b0, c - CNT_W'(1)};
  endfunction
`else
  // Wrapping count step.
  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c, input logic op);
    return op ? (c - CNT_W'(1)) : (c + CNT_W'(1));
  endfunction
`endif

  // FSM next-state, element capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    j_d        = j_q;
    clr_pend_d = clr_pend_q;
    key_d      = key_q;
    sig_d      = sig_q;
    idx_d      = idx_q;
    op_d       = op_q;
    mask_d     = mask_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_CLEAR: begin
        if (clr) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == IDX_W'(DEPTH - 1)) begin
          clr_addr_d = '0;
          state_d    = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + IDX_W'(1);
        end
      end
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = !clr;
        if (clr) begin
          clr_addr_d = '0;
          state_d    = S_CLEAR;
        end else if (in_valid) begin
          key_d  = in_key;
          sig_d  = in_hash[HASH_W-1 -: SIG_W];
          for (int j = 0; j < K_HASH; j++) idx_d[j] = in_hash[j*IDX_W +: IDX_W];
          op_d   = in_op;
          mask_d = in_bank_mask;
          j_d    = '0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (clr) clr_pend_d = 1'b1;
        if (j_q == J_W'(K_HASH - 1)) begin
          done = 1'b1;
          if (clr_pend_q || clr) begin
            clr_pend_d = 1'b0;
            clr_addr_d = '0;
            state_d    = S_CLEAR;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          j_d = j_q + J_W'(1);
        end
      end
      default: begin
        clr_addr_d = '0;
        state_d    = S_CLEAR;
      end
    endcase
    if (reset) begin
      in_ready = 1'b0;
      done     = 1'b0;
    end
  end

  // Bank contents: clear sweep or per-bank read-modify-write of the current index.
  always_comb begin
    mem_d    = mem_q;
    cur_idx  = '0;
    old_cell = '0;
    new_cnt  = '0;
`ifdef IBF_COUNT_SAT_EN
    sat_evt  = 1'b0;
    sat_b    = 1'b0;
`endif
    for (int j = 0; j < K_HASH; j++) begin
      if (j_q == J_W'(j)) cur_idx = idx_q[j];
    end
    if (state_q == S_CLEAR) begin
      for (int b = 0; b < NUM_IBF; b++) mem_d[b][clr_addr_q] = '0;
    end else if (state_q == S_UPDATE && !reset) begin
      for (int b = 0; b < NUM_IBF; b++) begin
        if (mask_q[b]) begin
          old_cell = mem_q[b][cur_idx];
`ifdef IBF_COUNT_SAT_EN
          {sat_b, new_cnt} = cnt_upd(old_cell[CNT_W-1:0], op_q);
          sat_evt = sat_evt | sat_b;
`else
          new_cnt = cnt_upd(old_cell[CNT_W-1:0], op_q);
`endif
          mem_d[b][cur_idx] = {old_cell[CELL_W-1 -: KEY_W] ^ key_q,
                               old_cell[SIG_W+CNT_W-1 -: SIG_W] ^ sig_q,
                               new_cnt};
        end
      end
    end
  end

  // Read port: registered lookup of the pre-write cell value; bad banks read 0.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int b = 0; b < NUM_IBF; b++) begin
        if (int'(rd_bank) == b) rd_data_d = mem_q[b][rd_addr];
      end
    end
  end

`ifdef IBF_COUNT_SAT_EN
  // Sticky saturation flag; clr wipes it together with the banks.
  always_comb begin
    cnt_err_d = cnt_err_q | sat_evt;
    if (clr) cnt_err_d = 1'b0;
  end

  assign cnt_err = cnt_err_q;
`endif

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      j_q        <= '0;
      clr_pend_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef IBF_COUNT_SAT_EN
      cnt_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      j_q        <= j_d;
      clr_pend_q <= clr_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef IBF_COUNT_SAT_EN
      cnt_err_q  <= cnt_err_d;
`endif
    end
  end

  // Element fields and bank storage; the clear sweep initialises the banks.
  always_ff @(posedge clk) begin
    key_q  <= key_d;
    sig_q  <= sig_d;
    idx_q  <= idx_d;
    op_q   <= op_d;
    mask_q <= mask_d;
    mem_q  <= mem_d;
  end

endmodule

// File: tb/tb_ibf_multi_bank_programmer.sv
// Testbench for ibf_multi_bank_programmer: directed and random elements,
// expected done cycles and read data queued at issue time from an array
// model, checked by an independent monitor on the falling clock edge.
module tb_ibf_multi_bank_programmer;

  localparam int KEY_W = 32, SIG_W = 8, CNT_W = 4, IDX_W = 4;
  localparam int NUM_IBF = 2, K_HASH = 3, DEPTH = 16;
  localparam int CELL_W = KEY_W + SIG_W + CNT_W;
  localparam int HASH_W = SIG_W + K_HASH * IDX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clr, in_valid, in_ready, in_op, done, busy;
  logic [1:0]        in_bank_mask;
  logic [KEY_W-1:0]  in_key;
  logic [HASH_W-1:0] in_hash;
  logic              rd_en, rd_valid;
  logic [0:0]        rd_bank;
  logic [IDX_W-1:0]  rd_addr;
  logic [CELL_W-1:0] rd_data;
`ifdef IBF_COUNT_SAT_EN
  logic              cnt_err;
`endif

  ibf_multi_bank_programmer dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_bank_mask(in_bank_mask), .in_key(in_key), .in_hash(in_hash),
    .done(done), .busy(busy),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data)
`ifdef IBF_COUNT_SAT_EN
    , .cnt_err(cnt_err)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                cyc;
    logic [CELL_W-1:0] data;
  } rd_exp_t;

  int      done_q[$];
  rd_exp_t rd_q[$];

  // Reference model: plain arrays of cell fields.
  logic [KEY_W-1:0] mk [NUM_IBF][DEPTH];
  logic [SIG_W-1:0] ms [NUM_IBF][DEPTH];
  logic [CNT_W-1:0] mc [NUM_IBF][DEPTH];
  bit               merr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NUM_IBF; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mk[b][a] = '0; ms[b][a] = '0; mc[b][a] = '0;
      end
    merr = 1'b0;
  endtask

  task automatic model_apply(input logic op, input logic [1:0] mask, input logic [KEY_W-1:0] key,
                             input logic [SIG_W-1:0] sig, input logic [IDX_W-1:0] i0,
                             input logic [IDX_W-1:0] i1, input logic [IDX_W-1:0] i2);
    logic [IDX_W-1:0] idx [3];
    idx[0] = i0; idx[1] = i1; idx[2] = i2;
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < NUM_IBF; b++)
        if (mask[b]) begin
          mk[b][idx[j]] ^= key;
          ms[b][idx[j]] ^= sig;
`ifdef IBF_COUNT_SAT_EN
          if (!op && mc[b][idx[j]] == 4'hF) merr = 1'b1;
          else if (op && mc[b][idx[j]] == 4'h0) merr = 1'b1;
          else mc[b][idx[j]] = op ? mc[b][idx[j]] - 4'd1 : mc[b][idx[j]] + 4'd1;
`else
          mc[b][idx[j]] = op ? mc[b][idx[j]] - 4'd1 : mc[b][idx[j]] + 4'd1;
`endif
        end
  endtask

  // Monitor: compare done pulses and read returns against the queued expectations.
  int mon_done_exp;
  rd_exp_t mon_rd;
  always @(negedge clk) begin
    if (!done && done_q.size() > 0 && done_q[0] < cyc) begin
      checks++; errors++;
      $display("FAIL done_missing: no pulse, required at cycle %0d", done_q[0]);
      void'(done_q.pop_front());
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        mon_done_exp = done_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_done_exp));
      end
    end
    if (!rd_valid && rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL rd_missing: no rd_valid, required at cycle %0d", rd_q[0].cyc);
      void'(rd_q.pop_front());
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: rd_valid at cycle %0d, required none", cyc);
      end else begin
        mon_rd = rd_q.pop_front();
        chk("rd_cycle", 64'(cyc), 64'(mon_rd.cyc));
        chk("rd_data", 64'(rd_data), 64'(mon_rd.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic op, input logic [1:0] mask, input logic [KEY_W-1:0] key,
                      input logic [SIG_W-1:0] sig, input logic [IDX_W-1:0] i0,
                      input logic [IDX_W-1:0] i1, input logic [IDX_W-1:0] i2, input bit expect_done);
    int n;
    in_op = op; in_bank_mask = mask; in_key = key;
    in_hash = {sig, i2, i1, i0};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready 0, required 1");
    end else if (expect_done) begin
      done_q.push_back(cyc + K_HASH);
      model_apply(op, mask, key, sig, i0, i1, i2);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("idle_reached", 64'(in_ready), 64'(1));
  endtask

  task automatic read_exp(input int b, input int a, input logic [CELL_W-1:0] exp);
    rd_exp_t e;
    rd_en = 1'b1; rd_bank = 1'(b); rd_addr = 4'(a);
    e.cyc = cyc + 1; e.data = exp;
    rd_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int b = 0; b < NUM_IBF; b++)
      for (int a = 0; a < DEPTH; a++)
        read_exp(b, a, {mk[b][a], ms[b][a], mc[b][a]});
    tick();
  endtask

  task automatic check_clear_window();
    for (int i = 0; i < DEPTH; i++) begin
      chk("clear_busy_ready", {62'b0, busy, in_ready}, 64'b10);
      tick();
    end
    chk("after_clear_busy_ready", {62'b0, busy, in_ready}, 64'b01);
  endtask

  task automatic check_err();
`ifdef IBF_COUNT_SAT_EN
    chk("cnt_err", 64'(cnt_err), 64'(merr));
`endif
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_bank_mask = '0;
    in_key = '0; in_hash = '0; rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
    model_clear();
    repeat (3) tick();
    chk("reset_outputs", {59'b0, in_ready, done, busy, rd_valid, 1'b0}, 64'b00100);
    chk("reset_rd_data", 64'(rd_data), 64'(0));
    check_err();
    reset = 1'b0;

    // Test 1: clear window length and empty banks.
    check_clear_window();
    read_all();

    // Test 2: simple insert into both banks.
    send(1'b0, 2'b11, 32'hDEADBEEF, 8'h5A, 4'd1, 4'd5, 4'd9, 1'b1);
    wait_idle();
    read_exp(0, 1, {32'hDEADBEEF, 8'h5A, 4'h1});
    read_exp(1, 9, {32'hDEADBEEF, 8'h5A, 4'h1});
    read_exp(0, 0, '0);
    read_all();

    // Test 3: duplicate index within one element, bank 0 only.
    send(1'b0, 2'b01, 32'h12345678, 8'h3C, 4'd3, 4'd3, 4'd7, 1'b1);
    wait_idle();
    read_exp(0, 3, {32'h0, 8'h0, 4'h2});
    read_exp(0, 7, {32'h12345678, 8'h3C, 4'h1});
    read_all();

    // Test 4: insert into bank 0, delete from both banks.
    send(1'b0, 2'b01, 32'hA5A5A5A5, 8'h66, 4'd2, 4'd4, 4'd6, 1'b1);
    send(1'b1, 2'b11, 32'hA5A5A5A5, 8'h66, 4'd2, 4'd4, 4'd6, 1'b1);
    wait_idle();
    read_all();
    check_err();

    // Test 5: reset during the second update cycle aborts the element.
    send(1'b0, 2'b11, 32'hCAFEF00D, 8'h11, 4'd8, 4'd9, 4'd10, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check_clear_window();
    read_all();
    check_err();
    send(1'b0, 2'b10, 32'h0BADF00D, 8'h77, 4'd12, 4'd13, 4'd14, 1'b1);
    wait_idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    check_clear_window();
    read_all();
    // clr during update is deferred until the element completes.
    send(1'b0, 2'b11, 32'h55AA55AA, 8'h22, 4'd0, 4'd15, 4'd7, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("clr_pending_busy", 64'(busy), 64'(1));
    model_clear();
    wait_idle();
    read_all();
    check_err();

    // Test 6: repeated inserts wrap (or saturate) the counts.
    for (int n = 0; n < 17; n++)
      send(1'b0, 2'b01, 32'h0F0F1234, 8'h99, 4'd0, 4'd1, 4'd2, 1'b1);
    wait_idle();
    read_exp(0, 0, {mk[0][0], ms[0][0], mc[0][0]});
    read_all();
    check_err();

    // Random elements against the model.
    for (int n = 0; n < 30; n++)
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 8'($urandom),
           4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    wait_idle();
    read_all();
    check_err();

    repeat (4) tick();
    chk("done_queue_drained", 64'(done_q.size()), 64'(0));
    chk("rd_queue_drained", 64'(rd_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
